instruction_memory: RTL and testbench



---
 rtl/instruction_memory.sv | 81 ++++++++
 tb/tb_instruction_memory.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Block-addressed 1 KiB instruction memory behind the instruction cache:
// fixed-latency 16-byte block reads plus a byte-wide program-load port.
module instruction_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [5:0]   address,
  output logic [127:0] readinst,
  output logic         busywait,
  input  logic         prog_write,
  input  logic [9:0]   prog_addr,
  input  logic [7:0]   prog_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [5:0]   addr_q;
  logic [7:0]   mem [0:1023];
  logic [127:0] block;

  // Program writes are locked out only while a read is in flight.
  always_ff @(posedge clock) begin
    if (prog_write && (state != BUSY)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    block = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      block[8*k +: 8] = mem[{addr_q, 4'(k)}];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      busywait <= 1'b0;
      readinst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            addr_q   <= address;
            cnt      <= 4'(LATENCY - 1);
            busywait <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            readinst <= block;
            busywait <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // A request still held high from the completed transfer is dropped here.
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busywait <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: a LATENCY=5 and a LATENCY=1 instance
// share all inputs; expected values are hand-computed from the byte pattern mem[k]=k.
module tb_instruction_memory;

  logic         clock;
  logic         reset;
  logic         read;
  logic [5:0]   address;
  logic         prog_write;
  logic [9:0]   prog_addr;
  logic [7:0]   prog_data;
  logic [127:0] readinst5;
  logic         busywait5;
  logic [127:0] readinst1;
  logic         busywait1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  instruction_memory #(.LATENCY(5)) u_lat5 (
    .clock      (clock),
    .reset      (reset),
    .read       (read),
    .address    (address),
    .readinst   (readinst5),
    .busywait   (busywait5),
    .prog_write (prog_write),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  instruction_memory #(.LATENCY(1)) u_lat1 (
    .clock      (clock),
    .reset      (reset),
    .read       (read),
    .address    (address),
    .readinst   (readinst1),
    .busywait   (busywait1),
    .prog_write (prog_write),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    read       = 1'b0;
    address    = '0;
    prog_write = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    #2;
    check("reset_busy5", 128'(busywait5), 128'd0);
    check("reset_data5", readinst5, 128'd0);
    check("reset_busy1", 128'(busywait1), 128'd0);
    check("reset_data1", readinst1, 128'd0);
    tick();
    reset = 1'b0;

    // Load mem[k] = k[7:0] into both instances
    prog_write = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      prog_addr = 10'(i);
      prog_data = 8'(i);
      tick();
    end
    prog_write = 1'b0;
    tick();

    // Basic read of block 3
    read = 1'b1; address = 6'd3;
    tick();
    check("basic_busy_e0", 128'(busywait5), 128'd1);
    read = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("basic_busy_e%0d", i), 128'(busywait5), 128'd1);
    end
    tick();
    check("basic_busy_done", 128'(busywait5), 128'd0);
    check("basic_data", readinst5, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
    tick();

    // Held request on block 2
    read = 1'b1; address = 6'd2;
    tick();
    check("held_busy_e0", 128'(busywait5), 128'd1);
    for (int i = 1; i <= 4; i++) tick();
    tick();
    check("held_busy_e5", 128'(busywait5), 128'd0);
    check("held_data", 128'(readinst5[7:0]), 128'h20);
    tick();
    check("held_busy_hold", 128'(busywait5), 128'd0);
    tick();
    check("held_recapture_e7", 128'(busywait5), 128'd1);
    read = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    tick();
    check("held_second_done", 128'(busywait5), 128'd0);
    tick();

    // Address change and read drop during BUSY
    read = 1'b1; address = 6'd1;
    tick();
    read = 1'b0; address = 6'd60;
    for (int i = 1; i <= 4; i++) tick();
    check("addrchg_still_busy", 128'(busywait5), 128'd1);
    tick();
    check("addrchg_busy_done", 128'(busywait5), 128'd0);
    check("addrchg_lo", 128'(readinst5[7:0]), 128'h10);
    check("addrchg_hi", 128'(readinst5[127:120]), 128'h1F);
    tick();

    // Reset during the third BUSY cycle
    read = 1'b1; address = 6'd5;
    tick();
    read = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 128'(busywait5), 128'd0);
    check("rst_mid_data", readinst5, 128'd0);
    #3;
    reset = 1'b0;
    tick();
    check("rst_release_idle", 128'(busywait5), 128'd0);
    read = 1'b1; address = 6'd5;
    tick();
    read = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("rst_fresh_busy_e4", 128'(busywait5), 128'd1);
    tick();
    check("rst_fresh_done", 128'(busywait5), 128'd0);
    check("rst_fresh_data", 128'(readinst5[7:0]), 128'h50);
    tick();

    // Program write concurrent with read, then a write during BUSY
    prog_write = 1'b1; prog_addr = 10'd48; prog_data = 8'hAA;
    read = 1'b1; address = 6'd3;
    tick();
    prog_write = 1'b0; read = 1'b0;
    tick();
    prog_write = 1'b1; prog_addr = 10'd49; prog_data = 8'h55;
    tick();
    prog_write = 1'b0;
    tick();
    tick();
    check("prog_busy_e4", 128'(busywait5), 128'd1);
    tick();
    check("prog_busy_done", 128'(busywait5), 128'd0);
    check("prog_same_edge", 128'(readinst5[7:0]), 128'hAA);
    check("prog_busy_ignored", 128'(readinst5[15:8]), 128'h31);
    tick();
    tick();

    // LATENCY=1 instance, top block
    read = 1'b1; address = 6'd63;
    tick();
    check("lat1_busy_e0", 128'(busywait1), 128'd1);
    read = 1'b0;
    tick();
    check("lat1_busy_done", 128'(busywait1), 128'd0);
    check("lat1_top_byte", 128'(readinst1[127:120]), 128'hFF);
    check("lat1_low_byte", 128'(readinst1[7:0]), 128'hF0);
    check("lat5_still_busy", 128'(busywait5), 128'd1);
    for (int i = 2; i <= 5; i++) tick();
    check("lat5_top_done", 128'(busywait5), 128'd0);
    check("lat5_top_data", readinst5, 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
